// File: rtl/mem_rd_burst_responder.sv
// Read-burst memory responder: serves 8-beat (32-byte line) bursts from a preloadable word store.
// Optional MEM_RSP_LAT_EN inserts RSP_LAT idle cycles between request accept and beat 0.
module mem_rd_burst_responder #(
  parameter int  DEPTH_WORDS = 1024,
  parameter int  RSP_LAT     = 4,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          from_cache_rd_req_valid,
  input  logic [31:0]   from_cache_rd_req_addr,
  output logic          to_cache_rd_req_ready,
  output logic          to_cache_rd_rsp_valid,
  output logic [31:0]   to_cache_rd_rsp_data,
  output logic          to_cache_rd_rsp_last,
  input  logic          from_cache_rd_rsp_ready,
  input  logic          preload_wen,
  input  logic [AW-1:0] preload_waddr,
  input  logic [31:0]   preload_wdata
);

  // Line index width; DEPTH_WORDS is expected to be at least 16.
  localparam int LW = AW - 3;

`ifdef MEM_RSP_LAT_EN
  typedef enum logic [1:0] {IDLE, LAT, SEND} state_t;
  logic [3:0] lat_cnt;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
  localparam int unused_lat = RSP_LAT;
`endif

  state_t        state, state_n;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [LW-1:0] line_q, req_line;
  logic [2:0]    beat, beat_n;
  logic          rdy_en, acc, beat_acc, load;
  logic [AW-1:0] load_idx;
  logic [31:0]   load_word;
  logic          unused_addr;

  assign req_line    = from_cache_rd_req_addr[5 +: LW];
  assign unused_addr = ^{from_cache_rd_req_addr[4:0], from_cache_rd_req_addr[31:5+LW]};

  // rdy_en keeps req_ready low while reset is held and until the first clock after release.
  assign to_cache_rd_req_ready = rdy_en && (state == IDLE);
  assign acc      = from_cache_rd_req_valid && to_cache_rd_req_ready;
  assign beat_acc = to_cache_rd_rsp_valid && from_cache_rd_rsp_ready;
  assign beat_n   = beat_acc ? beat + 3'd1 : beat;

  always_ff @(posedge clk) begin
    if (preload_wen) mem[preload_waddr] <= preload_wdata;
  end

  // A write landing on the same edge as the load of that word is forwarded into the beat.
  assign load_word = (preload_wen && preload_waddr == load_idx) ? preload_wdata : mem[load_idx];

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_idx = {line_q, beat_n};
    case (state)
      IDLE: if (acc) begin
`ifdef MEM_RSP_LAT_EN
        state_n = LAT;
`else
        state_n  = SEND;
        load     = 1'b1;
        load_idx = {req_line, 3'd0};
`endif
      end
`ifdef MEM_RSP_LAT_EN
      LAT: if (lat_cnt == 4'(RSP_LAT - 1)) begin
        state_n  = SEND;
        load     = 1'b1;
        load_idx = {line_q, 3'd0};
      end
`endif
      SEND: if (beat_acc) begin
        if (beat == 3'd7) state_n = IDLE;
        else              load    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      rdy_en                <= 1'b0;
      line_q                <= '0;
      beat                  <= '0;
      to_cache_rd_rsp_valid <= 1'b0;
      to_cache_rd_rsp_last  <= 1'b0;
      to_cache_rd_rsp_data  <= '0;
    end else begin
      state                 <= state_n;
      rdy_en                <= 1'b1;
      beat                  <= beat_n;
      if (acc)  line_q               <= req_line;
      if (load) to_cache_rd_rsp_data <= load_word;
      to_cache_rd_rsp_valid <= (state_n == SEND);
      to_cache_rd_rsp_last  <= (state_n == SEND) && (beat_n == 3'd7);
    end
  end

`ifdef MEM_RSP_LAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              lat_cnt <= '0;
    else if (state == LAT && state_n == LAT) lat_cnt <= lat_cnt + 4'd1;
    else                                   lat_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_mem_rd_burst_responder.sv
// Randomized self-checking bench for mem_rd_burst_responder against a word-array reference model.
module tb_mem_rd_burst_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LINES = DEPTH / 8;
  localparam int LATP  = 4;
`ifdef MEM_RSP_LAT_EN
  localparam int EXP_LAT = LATP + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          from_cache_rd_req_valid = 1'b0;
  logic [31:0]   from_cache_rd_req_addr  = '0;
  logic          to_cache_rd_req_ready;
  logic          to_cache_rd_rsp_valid;
  logic [31:0]   to_cache_rd_rsp_data;
  logic          to_cache_rd_rsp_last;
  logic          from_cache_rd_rsp_ready = 1'b0;
  logic          preload_wen   = 1'b0;
  logic [AW-1:0] preload_waddr = '0;
  logic [31:0]   preload_wdata = '0;

  mem_rd_burst_responder #(.DEPTH_WORDS(DEPTH), .RSP_LAT(LATP)) dut (
    .clk(clk), .rst(rst),
    .from_cache_rd_req_valid(from_cache_rd_req_valid),
    .from_cache_rd_req_addr(from_cache_rd_req_addr),
    .to_cache_rd_req_ready(to_cache_rd_req_ready),
    .to_cache_rd_rsp_valid(to_cache_rd_rsp_valid),
    .to_cache_rd_rsp_data(to_cache_rd_rsp_data),
    .to_cache_rd_rsp_last(to_cache_rd_rsp_last),
    .from_cache_rd_rsp_ready(from_cache_rd_rsp_ready),
    .preload_wen(preload_wen),
    .preload_waddr(preload_waddr),
    .preload_wdata(preload_wdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] got_data [8];
  logic        got_last [8];
  int got_n, lat, span, hold_err, b2_cycles;
  logic ready_after, valid_after;

  function automatic int word_of(input logic [31:0] a, input int k);
    return int'((a >> 5) % LINES) * 8 + k;
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    preload_wen = 1'b1; preload_waddr = AW'(idx); preload_wdata = d;
    @(posedge clk); #1;
    preload_wen = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Issues one request and collects the burst; mode 0 = always ready, 1 = 3-cycle stall on beat 2,
  // 2 = random backpressure. Optional preload write while beat 1 is presented.
  task automatic run_burst(input logic [31:0] a, input int mode, input logic col_en,
                           input int col_idx, input logic [31:0] col_dat);
    int cyc, stall;
    logic accepted, col_done, prev_hold;
    logic [31:0] prev_data;
    got_n = 0; lat = -1; span = 0; hold_err = 0; b2_cycles = 0;
    ready_after = 1'b0; valid_after = 1'b1; accepted = 1'b0;
    for (int k = 0; k < 8; k++) begin got_data[k] = '0; got_last[k] = 1'b0; end
    from_cache_rd_req_valid = 1'b1; from_cache_rd_req_addr = a;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (to_cache_rd_req_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    from_cache_rd_req_valid = 1'b0; from_cache_rd_req_addr = $urandom;
    if (accepted) begin
      cyc = 1; stall = 0; col_done = 1'b0; prev_hold = 1'b0; prev_data = '0;
      while (got_n < 8 && cyc < 200) begin
        if (prev_hold && (!to_cache_rd_rsp_valid || to_cache_rd_rsp_data !== prev_data)) hold_err++;
        if (to_cache_rd_rsp_valid && lat < 0) lat = cyc;
        if (to_cache_rd_rsp_valid && got_n == 2) b2_cycles++;
        from_cache_rd_rsp_ready = 1'b1;
        if (mode == 1 && to_cache_rd_rsp_valid && got_n == 2 && stall < 3) begin
          from_cache_rd_rsp_ready = 1'b0; stall++;
        end
        if (mode == 2) from_cache_rd_rsp_ready = ($urandom_range(0, 2) != 0);
        preload_wen = 1'b0;
        if (col_en && to_cache_rd_rsp_valid && got_n == 1 && !col_done) begin
          preload_wen = 1'b1; preload_waddr = AW'(col_idx); preload_wdata = col_dat;
          col_done = 1'b1; ref_mem[col_idx] = col_dat;
        end
        prev_hold = to_cache_rd_rsp_valid && !from_cache_rd_rsp_ready;
        prev_data = to_cache_rd_rsp_data;
        if (to_cache_rd_rsp_valid && from_cache_rd_rsp_ready) begin
          got_data[got_n] = to_cache_rd_rsp_data;
          got_last[got_n] = to_cache_rd_rsp_last;
          if (got_n == 7) span = cyc - lat + 1;
          got_n++;
        end
        @(posedge clk); #1; cyc++;
      end
      preload_wen = 1'b0; from_cache_rd_rsp_ready = 1'b0;
      ready_after = to_cache_rd_req_ready; valid_after = to_cache_rd_rsp_valid;
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (to_cache_rd_rsp_valid !== 1'b0 || to_cache_rd_rsp_last !== 1'b0 ||
        to_cache_rd_rsp_data !== 32'h0 || to_cache_rd_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b last=%b data=%h ready=%b want 0/0/0/0",
               to_cache_rd_rsp_valid, to_cache_rd_rsp_last, to_cache_rd_rsp_data, to_cache_rd_req_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (to_cache_rd_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", to_cache_rd_req_ready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) preload(32'h40 + i, 32'hA0 + i);
    run_burst(32'h100, 0, 1'b0, 0, '0);
    n_tests++;
    if (got_n !== 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", got_n); end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (got_data[k] !== 32'hA0 + k || got_last[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got %h last %b want %h last %b", k, got_data[k], got_last[k], 32'hA0 + k, k == 7);
      end
    end
    n_tests++;
    if (lat !== EXP_LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, EXP_LAT); end
    n_tests++;
    if (span !== 8) begin n_fail++; $display("FAIL basic_consecutive: got %0d want 8", span); end
    n_tests++;
    if (ready_after !== 1'b1 || valid_after !== 1'b0) begin
      n_fail++; $display("FAIL basic_after: ready %b valid %b want 1 0", ready_after, valid_after);
    end
  endtask

  task automatic test_backpressure();
    run_burst(32'h100, 1, 1'b0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (got_data[k] !== 32'hA0 + k || got_last[k] !== (k == 7)) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h last %b want %h", k, got_data[k], got_last[k], 32'hA0 + k);
      end
    end
    n_tests++;
    if (b2_cycles !== 4) begin n_fail++; $display("FAIL bp_beat2_cycles: got %0d want 4", b2_cycles); end
    n_tests++;
    if (hold_err !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d changes want 0", hold_err); end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [2];
    addrs[0] = 32'h2100; addrs[1] = 32'h011C;
    for (int t = 0; t < 2; t++) begin
      run_burst(addrs[t], 0, 1'b0, 0, '0);
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (got_data[k] !== ref_mem[32'h40 + k]) begin
          n_fail++; $display("FAIL wrap_%h_beat%0d: got %h want %h", addrs[t], k, got_data[k], ref_mem[32'h40 + k]);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] old1;
    run_burst(32'h100, 0, 1'b1, 32'h45, 32'hDEAD);
    n_tests++;
    if (got_data[5] !== 32'hDEAD) begin n_fail++; $display("FAIL col_future_beat5: got %h want 0000dead", got_data[5]); end
    old1 = ref_mem[32'h41];
    run_burst(32'h100, 0, 1'b1, 32'h41, 32'hBEEF);
    n_tests++;
    if (got_data[1] !== old1) begin n_fail++; $display("FAIL col_loaded_beat1: got %h want %h", got_data[1], old1); end
    run_burst(32'h100, 0, 1'b0, 0, '0);
    n_tests++;
    if (got_data[1] !== 32'hBEEF) begin n_fail++; $display("FAIL col_write_landed: got %h want 0000beef", got_data[1]); end
  endtask

  task automatic test_reset_mid();
    logic acc_ok = 1'b0;
    int seen = 0;
    from_cache_rd_req_valid = 1'b1; from_cache_rd_req_addr = 32'h100;
    for (int i = 0; i < 20 && !acc_ok; i++) begin
      if (to_cache_rd_req_ready) acc_ok = 1'b1;
      @(posedge clk); #1;
    end
    from_cache_rd_req_valid = 1'b0; from_cache_rd_rsp_ready = 1'b1;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      if (to_cache_rd_rsp_valid) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (to_cache_rd_rsp_valid !== 1'b1 || to_cache_rd_rsp_data !== ref_mem[32'h43]) begin
      n_fail++; $display("FAIL rstmid_beat3: valid %b data %h want 1 %h", to_cache_rd_rsp_valid, to_cache_rd_rsp_data, ref_mem[32'h43]);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (to_cache_rd_rsp_valid !== 1'b0 || to_cache_rd_rsp_last !== 1'b0 || to_cache_rd_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async_drop: valid %b last %b ready %b want 0 0 0",
                         to_cache_rd_rsp_valid, to_cache_rd_rsp_last, to_cache_rd_req_ready);
    end
    from_cache_rd_rsp_ready = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (to_cache_rd_req_ready !== 1'b1 || to_cache_rd_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_release: ready %b valid %b want 1 0", to_cache_rd_req_ready, to_cache_rd_rsp_valid);
    end
    run_burst(32'h3E0, 0, 1'b0, 0, '0);
    n_tests++;
    if (got_n !== 8) begin n_fail++; $display("FAIL rstmid_new_count: got %0d want 8", got_n); end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (got_data[k] !== ref_mem[word_of(32'h3E0, k)] || got_last[k] !== (k == 7)) begin
        n_fail++; $display("FAIL rstmid_new_beat%0d: got %h want %h", k, got_data[k], ref_mem[word_of(32'h3E0, k)]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int it = 0; it < 16; it++) begin
      a = $urandom;
      if (it % 3 == 0) preload(word_of(a, $urandom_range(0, 7)), $urandom);
      run_burst(a, 2, 1'b0, 0, '0);
      n_tests++;
      if (got_n !== 8 || hold_err !== 0 || lat !== EXP_LAT) begin
        n_fail++; $display("FAIL rand%0d_ctrl: beats %0d holderr %0d lat %0d want 8 0 %0d", it, got_n, hold_err, lat, EXP_LAT);
      end
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (got_data[k] !== ref_mem[word_of(a, k)] || got_last[k] !== (k == 7)) begin
          n_fail++; $display("FAIL rand%0d_beat%0d addr %h: got %h last %b want %h",
                             it, k, a, got_data[k], got_last[k], ref_mem[word_of(a, k)]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    test_basic();
    test_backpressure();
    test_wrap();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
